rr_packet_router: RTL and testbench
===================================

Name: rr_packet_router

Overview:
- Sequential, parametrised successor to the two-channel combinational router benchmark.
- Routes multi-flit packets from NUM_IN input channels to NUM_OUT output channels using valid/ready handshakes.
- Each output has its own round-robin arbiter that holds a lock for the whole packet, plus a one-entry output register.
- Invalid destinations are dropped and counted.
- Used as a sequential benchmark and scheduling target next to the combinational router netlist.

Parameters:
NUM_IN, 4, number of input channels (2..8)
NUM_OUT, 2, number of output channels (1..8)
DATA_W, 16, flit payload width
DEST_W, 3, destination field width; 2**DEST_W >= NUM_OUT
CNT_W, 8, width of the drop counter

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  NUM_IN  per-input flit valid
in_ready  output  NUM_IN  per-input flit accepted this cycle
in_data  input  NUM_IN*DATA_W  payloads, channel i at [i*DATA_W +: DATA_W]
in_dest  input  NUM_IN*DEST_W  destination index, sampled on every flit; only the head flit's value is used
in_last  input  NUM_IN  flit is the final flit of its packet
out_valid  output  NUM_OUT  output register holds a flit
out_ready  input  NUM_OUT  downstream accepts
out_data  output  NUM_OUT*DATA_W  registered payload
out_last  output  NUM_OUT  registered last flag
out_src  output  NUM_OUT*$clog2(NUM_IN)  source channel of the registered flit
drop_cnt  output  CNT_W  saturating count of dropped flits

Behaviour:
- Reset (rst=1 at an edge): all out_valid=0; out_data, out_last, out_src, drop_cnt=0; all arbiters IDLE; round-robin pointers=0; per-input head flags=1.
- Reset mid-packet discards the partial packet. in_ready is 0 during any cycle in which rst=1.
- Head tracking: an input's flit is a head flit when its head flag=1. A transfer (valid&ready) of a flit sets head=in_last.
- Routing target: a head flit routes to in_dest. The target is latched per input for the body flits of that packet.
- Drop path:
  - A head flit with in_dest >= NUM_OUT puts the input in DROP mode.
  - Every flit of that packet gets in_ready=1 unconditionally and increments drop_cnt by 1.
  - drop_cnt saturates at 2**CNT_W-1.
  - DROP mode ends after the flit with in_last=1 transfers.
- Per-output arbiter FSM:
  - IDLE:
    - Among inputs presenting a valid head flit for this output, grant the first one at index >= ptr, wrapping modulo NUM_IN.
    - The arbitration decision is combinational in the same cycle.
    - Move to LOCKED(owner) when the head flit transfers. If that head flit also has in_last=1, stay IDLE.
    - On a packet completing, ptr = owner+1 mod NUM_IN.
  - LOCKED(owner):
    - Only the owner may transfer to this output. Other inputs targeting it see in_ready=0.
    - Return to IDLE when the owner's in_last flit transfers.
- Handshake:
  - in_ready[i] = granted(i) & (!out_valid[o] | out_ready[o]).
  - An input targets at most one output at a time.
  - in_valid must stay high and the flit must stay stable until ready. The bench checks this, and the RTL does not need to tolerate violations.
- Output register:
  - On a transfer, load data/last/src and set out_valid the next cycle. Latency is exactly 1 cycle from input transfer to out_valid.
  - Simultaneous out_ready and a new transfer gives back-to-back flits with no bubble. Sustained throughput is 1 flit/cycle per output.
  - out_valid clears when out_ready=1 and no new transfer occurs.
  - The register holds stable while out_valid & !out_ready.
- Independence: outputs operate fully in parallel. Two inputs can route to two different outputs in the same cycle.
- Single-flit packets: arbitrate every cycle; the round-robin pointer advances on each one.

Test Plan:
- Single packet, NUM_IN=4, NUM_OUT=2: input 2 sends 3 flits {0x11,0x22,0x33} with dest=1 and out_ready=1 → out_valid[1] is high for 3 consecutive cycles starting 1 cycle after the first transfer; out_src[1]=2; out_last is only on 0x33; output 0 stays idle.
- Contention: inputs 0, 1, 3 each send a 2-flit packet to dest 0 at the same time, ptr=0 → packets emerge in order 0, 1, 3 with no interleaving and no idle cycles; ptr ends at 0 (3+1 mod 4).
- Backpressure: out_ready[0]=0 for 5 cycles mid-packet → out_data held constant, in_ready of the owner is 0 while the register is full; no flit is lost or duplicated after release.
- Drop: head flit with dest=5 (NUM_OUT=2), 4-flit packet → in_ready=1 each cycle, outputs untouched, drop_cnt goes 0→4. With CNT_W=2 and 5 dropped flits → drop_cnt=3.
- Parallel paths: input 0 → dest 0 and input 1 → dest 1, both single-flit, in the same cycle → both out_valid rise together next cycle with correct data and src.
- Reset mid-packet: assert rst during flit 2 of 4 → next cycle all out_valid=0 and drop_cnt=0. A fresh packet from the same input is then treated as a head flit and routed by its new in_dest.

Source files
------------

// File: rtl/rr_packet_router.sv
// Multi-flit packet router: NUM_IN inputs to NUM_OUT outputs, one round-robin
// arbiter with packet lock and a one-entry output register per output.
module rr_packet_router #(
    parameter int NUM_IN  = 4,
    parameter int NUM_OUT = 2,
    parameter int DATA_W  = 16,
    parameter int DEST_W  = 3,
    parameter int CNT_W   = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_IN-1:0]                 in_valid,
    output logic [NUM_IN-1:0]                 in_ready,
    input  logic [NUM_IN*DATA_W-1:0]          in_data,
    input  logic [NUM_IN*DEST_W-1:0]          in_dest,
    input  logic [NUM_IN-1:0]                 in_last,
    output logic [NUM_OUT-1:0]                out_valid,
    input  logic [NUM_OUT-1:0]                out_ready,
    output logic [NUM_OUT*DATA_W-1:0]         out_data,
    output logic [NUM_OUT-1:0]                out_last,
    output logic [NUM_OUT*$clog2(NUM_IN)-1:0] out_src,
    output logic [CNT_W-1:0]                  drop_cnt
);
    localparam int SRC_W = $clog2(NUM_IN);

    typedef enum logic {IDLE, LOCKED} arb_state_t;

    logic [NUM_IN-1:0] head;
    logic [NUM_IN-1:0] drop;
    logic [DEST_W-1:0] tgt [NUM_IN];
    arb_state_t        state [NUM_OUT];
    logic [SRC_W-1:0]  owner [NUM_OUT];
    logic [SRC_W-1:0]  ptr [NUM_OUT];

    logic [DEST_W-1:0] dest_now [NUM_IN];
    logic [NUM_IN-1:0] drop_now;
    logic [NUM_IN-1:0] xfer_in;
    logic [NUM_IN-1:0] drop_xfer;
    logic [NUM_IN-1:0] gnt [NUM_OUT];
    logic [SRC_W-1:0]  sel [NUM_OUT];
    logic [NUM_OUT-1:0] space;
    logic [NUM_OUT-1:0] xfer_out;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input int n);
        int s;
        int mx;
        mx = (1 << CNT_W) - 1;
        s  = int'(a) + n;
        if (s > mx) s = mx;
        return CNT_W'(s);
    endfunction

    function automatic logic [SRC_W-1:0] next_ptr(input logic [SRC_W-1:0] p);
        int n;
        n = int'(p) + 1;
        if (n >= NUM_IN) n = 0;
        return SRC_W'(n);
    endfunction

    // Head flits take their destination live; body flits reuse the latched one.
    always_comb begin : route
        for (int i = 0; i < NUM_IN; i++) begin
            dest_now[i] = head[i] ? in_dest[i*DEST_W +: DEST_W] : tgt[i];
            drop_now[i] = head[i] ? (int'(in_dest[i*DEST_W +: DEST_W]) >= NUM_OUT) : drop[i];
        end
    end

    always_comb begin : arbitrate
        int               idx;
        logic [SRC_W-1:0] ib;
        logic             found;
        idx   = 0;
        ib    = '0;
        found = 1'b0;
        for (int o = 0; o < NUM_OUT; o++) begin
            gnt[o]   = '0;
            sel[o]   = '0;
            found    = 1'b0;
            space[o] = !out_valid[o] || out_ready[o];
            if (state[o] == LOCKED) begin
                gnt[o][owner[o]] = 1'b1;
                sel[o]           = owner[o];
            end else begin
                for (int k = 0; k < NUM_IN; k++) begin
                    idx = (int'(ptr[o]) + k) % NUM_IN;
                    ib  = SRC_W'(idx);
                    if (!found && in_valid[ib] && head[ib] && !drop_now[ib]
                        && int'(dest_now[ib]) == o) begin
                        gnt[o][ib] = 1'b1;
                        sel[o]     = ib;
                        found      = 1'b1;
                    end
                end
            end
            xfer_out[o] = !rst && space[o] && |(gnt[o] & in_valid);
        end
    end

    always_comb begin : handshake
        in_ready = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            in_ready[i] = drop_now[i];
            for (int o = 0; o < NUM_OUT; o++) begin
                in_ready[i] = in_ready[i] | (gnt[o][i] & space[o]);
            end
        end
        if (rst) in_ready = '0;
        xfer_in   = in_valid & in_ready;
        drop_xfer = xfer_in & drop_now;
    end

    // Stage boundary: input transfer -> output register, one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= '1;
            drop      <= '0;
            out_valid <= '0;
            out_data  <= '0;
            out_last  <= '0;
            out_src   <= '0;
            drop_cnt  <= '0;
            for (int i = 0; i < NUM_IN; i++) tgt[i] <= '0;
            for (int o = 0; o < NUM_OUT; o++) begin
                state[o] <= IDLE;
                owner[o] <= '0;
                ptr[o]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (xfer_in[i]) begin
                    head[i] <= in_last[i];
                    drop[i] <= drop_now[i] & !in_last[i];
                    tgt[i]  <= dest_now[i];
                end
            end
            drop_cnt <= sat_add(drop_cnt, $countones(drop_xfer));
            for (int o = 0; o < NUM_OUT; o++) begin
                if (xfer_out[o]) begin
                    out_valid[o]                  <= 1'b1;
                    out_data[o*DATA_W +: DATA_W]  <= in_data[sel[o]*DATA_W +: DATA_W];
                    out_last[o]                   <= in_last[sel[o]];
                    out_src[o*SRC_W +: SRC_W]     <= sel[o];
                    if (in_last[sel[o]]) begin
                        state[o] <= IDLE;
                        ptr[o]   <= next_ptr(sel[o]);
                    end else begin
                        state[o] <= LOCKED;
                        owner[o] <= sel[o];
                    end
                end else if (out_ready[o]) begin
                    out_valid[o] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_rr_packet_router.sv
// Directed, table-driven bench for rr_packet_router (4 in, 2 out) plus a
// CNT_W=2 copy sharing the same stimulus for drop-counter saturation.
module tb_rr_packet_router;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [63:0] in_data;
    logic [11:0] in_dest;
    logic [3:0]  in_last;
    logic [1:0]  out_valid;
    logic [1:0]  out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_last;
    logic [3:0]  out_src;
    logic [7:0]  drop_cnt;

    logic [3:0]  in_ready2;
    logic [1:0]  out_valid2;
    logic [31:0] out_data2;
    logic [1:0]  out_last2;
    logic [3:0]  out_src2;
    logic [1:0]  drop_cnt2;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rr_packet_router #(.NUM_IN(4), .NUM_OUT(2), .DATA_W(16), .DEST_W(3), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_dest(in_dest), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .out_src(out_src), .drop_cnt(drop_cnt)
    );

    rr_packet_router #(.NUM_IN(4), .NUM_OUT(2), .DATA_W(16), .DEST_W(3), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .in_dest(in_dest), .in_last(in_last), .out_valid(out_valid2), .out_ready(out_ready),
        .out_data(out_data2), .out_last(out_last2), .out_src(out_src2), .drop_cnt(drop_cnt2)
    );

    typedef struct {
        string       name;
        logic [3:0]  v;
        logic [63:0] d;
        logic [11:0] dst;
        logic [3:0]  l;
        logic [1:0]  ordy;
        logic [3:0]  rdy;
        logic [1:0]  ov;
        logic [31:0] od;
        logic [1:0]  ol;
        logic [3:0]  os;
        logic [7:0]  dc;
        logic [1:0]  dc2;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [63:0] pk(input logic [15:0] a3, input logic [15:0] a2,
                                       input logic [15:0] a1, input logic [15:0] a0);
        return {a3, a2, a1, a0};
    endfunction

    function automatic logic [11:0] dp(input logic [2:0] t3, input logic [2:0] t2,
                                       input logic [2:0] t1, input logic [2:0] t0);
        return {t3, t2, t1, t0};
    endfunction

    task automatic add(input string nm, input logic [3:0] v, input logic [63:0] d,
                       input logic [11:0] dst, input logic [3:0] l, input logic [1:0] ordy,
                       input logic [3:0] rdy, input logic [1:0] ov, input logic [31:0] od,
                       input logic [1:0] ol, input logic [3:0] os, input logic [7:0] dc,
                       input logic [1:0] dc2);
        vec_t r;
        r.name = nm; r.v = v; r.d = d; r.dst = dst; r.l = l; r.ordy = ordy;
        r.rdy = rdy; r.ov = ov; r.od = od; r.ol = ol; r.os = os; r.dc = dc; r.dc2 = dc2;
        tbl.push_back(r);
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [63:0] d, input logic [11:0] dst,
                         input logic [3:0] l);
        in_valid = v;
        in_data  = d;
        in_dest  = dst;
        in_last  = l;
    endtask

    initial begin
        logic [31:0] dm;
        logic [3:0]  sm;
        logic [63:0] act;
        logic [63:0] exp;

        // Single 3-flit packet, input 2 -> output 1
        add("t1_f0", 4'b0100, pk(0, 16'h11, 0, 0), dp(0, 1, 0, 0), 4'b0000, 2'b11, 4'b0100, 2'b00, 32'h0, 2'b00, 4'b0000, 8'd0, 2'd0);
        add("t1_f1", 4'b0100, pk(0, 16'h22, 0, 0), dp(0, 1, 0, 0), 4'b0000, 2'b11, 4'b0100, 2'b10, {16'h11, 16'h0}, 2'b00, 4'b1000, 8'd0, 2'd0);
        add("t1_f2", 4'b0100, pk(0, 16'h33, 0, 0), dp(0, 1, 0, 0), 4'b0100, 2'b11, 4'b0100, 2'b10, {16'h22, 16'h0}, 2'b00, 4'b1000, 8'd0, 2'd0);
        add("t1_o2", 4'b0000, 64'h0, 12'h0, 4'b0000, 2'b11, 4'b0000, 2'b10, {16'h33, 16'h0}, 2'b10, 4'b1000, 8'd0, 2'd0);
        add("t1_idle", 4'b0000, 64'h0, 12'h0, 4'b0000, 2'b11, 4'b0000, 2'b00, 32'h0, 2'b00, 4'b0000, 8'd0, 2'd0);
        // Contention: inputs 0,1,3 each 2 flits to output 0
        add("t2_c0", 4'b1011, pk(16'hD000, 0, 16'hB000, 16'hA000), 12'h0, 4'b0000, 2'b11, 4'b0001, 2'b00, 32'h0, 2'b00, 4'b0000, 8'd0, 2'd0);
        add("t2_c1", 4'b1011, pk(16'hD000, 0, 16'hB000, 16'hA001), 12'h0, 4'b0001, 2'b11, 4'b0001, 2'b01, {16'h0, 16'hA000}, 2'b00, 4'b0000, 8'd0, 2'd0);
        add("t2_c2", 4'b1010, pk(16'hD000, 0, 16'hB000, 0), 12'h0, 4'b0000, 2'b11, 4'b0010, 2'b01, {16'h0, 16'hA001}, 2'b01, 4'b0000, 8'd0, 2'd0);
        add("t2_c3", 4'b1010, pk(16'hD000, 0, 16'hB001, 0), 12'h0, 4'b0010, 2'b11, 4'b0010, 2'b01, {16'h0, 16'hB000}, 2'b00, 4'b0001, 8'd0, 2'd0);
        add("t2_c4", 4'b1000, pk(16'hD000, 0, 0, 0), 12'h0, 4'b0000, 2'b11, 4'b1000, 2'b01, {16'h0, 16'hB001}, 2'b01, 4'b0001, 8'd0, 2'd0);
        add("t2_c5", 4'b1000, pk(16'hD001, 0, 0, 0), 12'h0, 4'b1000, 2'b11, 4'b1000, 2'b01, {16'h0, 16'hD000}, 2'b00, 4'b0011, 8'd0, 2'd0);
        add("t2_c6", 4'b0000, 64'h0, 12'h0, 4'b0000, 2'b11, 4'b0000, 2'b01, {16'h0, 16'hD001}, 2'b01, 4'b0011, 8'd0, 2'd0);
        add("t2_idle", 4'b0000, 64'h0, 12'h0, 4'b0000, 2'b11, 4'b0000, 2'b00, 32'h0, 2'b00, 4'b0000, 8'd0, 2'd0);
        // Single-flit packets from inputs 1 and 3: pointer advances every packet
        add("t3_s0", 4'b1010, pk(16'hC003, 0, 16'hC001, 0), 12'h0, 4'b1010, 2'b11, 4'b0010, 2'b00, 32'h0, 2'b00, 4'b0000, 8'd0, 2'd0);
        add("t3_s1", 4'b1000, pk(16'hC003, 0, 0, 0), 12'h0, 4'b1000, 2'b11, 4'b1000, 2'b01, {16'h0, 16'hC001}, 2'b01, 4'b0001, 8'd0, 2'd0);
        add("t3_s2", 4'b1010, pk(16'hE003, 0, 16'hE001, 0), 12'h0, 4'b1010, 2'b11, 4'b0010, 2'b01, {16'h0, 16'hC003}, 2'b01, 4'b0011, 8'd0, 2'd0);
        add("t3_s3", 4'b1000, pk(16'hE003, 0, 0, 0), 12'h0, 4'b1000, 2'b11, 4'b1000, 2'b01, {16'h0, 16'hE001}, 2'b01, 4'b0001, 8'd0, 2'd0);
        add("t3_s4", 4'b0000, 64'h0, 12'h0, 4'b0000, 2'b11, 4'b0000, 2'b01, {16'h0, 16'hE003}, 2'b01, 4'b0011, 8'd0, 2'd0);
        add("t3_idle", 4'b0000, 64'h0, 12'h0, 4'b0000, 2'b11, 4'b0000, 2'b00, 32'h0, 2'b00, 4'b0000, 8'd0, 2'd0);
        // Backpressure on output 0 for 5 cycles mid-packet
        add("t4_b0", 4'b0010, pk(0, 0, 16'h0101, 0), 12'h0, 4'b0000, 2'b11, 4'b0010, 2'b00, 32'h0, 2'b00, 4'b0000, 8'd0, 2'd0);
        for (int k = 0; k < 5; k++)
            add("t4_hold", 4'b0010, pk(0, 0, 16'h0102, 0), 12'h0, 4'b0000, 2'b10, 4'b0000, 2'b01, {16'h0, 16'h0101}, 2'b00, 4'b0001, 8'd0, 2'd0);
        add("t4_rel", 4'b0010, pk(0, 0, 16'h0102, 0), 12'h0, 4'b0000, 2'b11, 4'b0010, 2'b01, {16'h0, 16'h0101}, 2'b00, 4'b0001, 8'd0, 2'd0);
        add("t4_b2", 4'b0010, pk(0, 0, 16'h0103, 0), 12'h0, 4'b0010, 2'b11, 4'b0010, 2'b01, {16'h0, 16'h0102}, 2'b00, 4'b0001, 8'd0, 2'd0);
        add("t4_o3", 4'b0000, 64'h0, 12'h0, 4'b0000, 2'b11, 4'b0000, 2'b01, {16'h0, 16'h0103}, 2'b01, 4'b0001, 8'd0, 2'd0);
        add("t4_idle", 4'b0000, 64'h0, 12'h0, 4'b0000, 2'b11, 4'b0000, 2'b00, 32'h0, 2'b00, 4'b0000, 8'd0, 2'd0);
        // Drop: 4-flit packet to dest 5, then a 1-flit packet to dest 7
        add("t5_d0", 4'b1000, pk(16'hDD01, 0, 0, 0), dp(5, 0, 0, 0), 4'b0000, 2'b11, 4'b1000, 2'b00, 32'h0, 2'b00, 4'b0000, 8'd0, 2'd0);
        add("t5_d1", 4'b1000, pk(16'hDD02, 0, 0, 0), dp(5, 0, 0, 0), 4'b0000, 2'b11, 4'b1000, 2'b00, 32'h0, 2'b00, 4'b0000, 8'd1, 2'd1);
        add("t5_d2", 4'b1000, pk(16'hDD03, 0, 0, 0), dp(5, 0, 0, 0), 4'b0000, 2'b11, 4'b1000, 2'b00, 32'h0, 2'b00, 4'b0000, 8'd2, 2'd2);
        add("t5_d3", 4'b1000, pk(16'hDD04, 0, 0, 0), dp(5, 0, 0, 0), 4'b1000, 2'b11, 4'b1000, 2'b00, 32'h0, 2'b00, 4'b0000, 8'd3, 2'd3);
        add("t5_cnt4", 4'b0000, 64'h0, 12'h0, 4'b0000, 2'b11, 4'b0000, 2'b00, 32'h0, 2'b00, 4'b0000, 8'd4, 2'd3);
        add("t5_d4", 4'b1000, pk(16'hDD05, 0, 0, 0), dp(7, 0, 0, 0), 4'b1000, 2'b11, 4'b1000, 2'b00, 32'h0, 2'b00, 4'b0000, 8'd4, 2'd3);
        add("t5_cnt5", 4'b0000, 64'h0, 12'h0, 4'b0000, 2'b11, 4'b0000, 2'b00, 32'h0, 2'b00, 4'b0000, 8'd5, 2'd3);
        // Parallel: input 0 -> out 0, input 1 -> out 1
        add("t6_p0", 4'b0011, pk(0, 0, 16'h00F1, 16'h00F0), dp(0, 0, 1, 0), 4'b0011, 2'b11, 4'b0011, 2'b00, 32'h0, 2'b00, 4'b0000, 8'd5, 2'd3);
        add("t6_p1", 4'b0000, 64'h0, 12'h0, 4'b0000, 2'b11, 4'b0000, 2'b11, {16'h00F1, 16'h00F0}, 2'b11, 4'b0100, 8'd5, 2'd3);
        add("t6_idle", 4'b0000, 64'h0, 12'h0, 4'b0000, 2'b11, 4'b0000, 2'b00, 32'h0, 2'b00, 4'b0000, 8'd5, 2'd3);

        rst = 1'b1;
        out_ready = 2'b11;
        drive(4'b0, 64'h0, 12'h0, 4'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_state", {in_ready, out_valid, out_data, out_last, out_src, drop_cnt, drop_cnt2},
              64'h0);

        foreach (tbl[k]) begin
            @(negedge clk);
            drive(tbl[k].v, tbl[k].d, tbl[k].dst, tbl[k].l);
            out_ready = tbl[k].ordy;
            #1;
            dm  = {{16{tbl[k].ov[1]}}, {16{tbl[k].ov[0]}}};
            sm  = {{2{tbl[k].ov[1]}}, {2{tbl[k].ov[0]}}};
            act = {10'h0, in_ready, out_valid, out_data & dm, out_last & tbl[k].ov,
                   out_src & sm, drop_cnt, drop_cnt2};
            exp = {10'h0, tbl[k].rdy, tbl[k].ov, tbl[k].od & dm, tbl[k].ol & tbl[k].ov,
                   tbl[k].os & sm, tbl[k].dc, tbl[k].dc2};
            check(tbl[k].name, act, exp);
        end

        // Reset in the middle of a 4-flit packet from input 2 to output 0
        @(negedge clk);
        drive(4'b0100, pk(0, 16'h0A01, 0, 0), dp(0, 0, 0, 0), 4'b0000);
        @(negedge clk);
        drive(4'b0100, pk(0, 16'h0A02, 0, 0), dp(0, 0, 0, 0), 4'b0000);
        rst = 1'b1;
        #1;
        check("rst_ready_low", {60'h0, in_ready}, 64'h0);
        check("rst_pre_valid", {62'h0, out_valid}, 64'h1);
        @(negedge clk);
        rst = 1'b0;
        drive(4'b0, 64'h0, 12'h0, 4'b0);
        #1;
        check("rst_clear", {out_valid, drop_cnt, drop_cnt2}, 64'h0);
        @(negedge clk);
        drive(4'b0100, pk(0, 16'h0B01, 0, 0), dp(0, 1, 0, 0), 4'b0100);
        #1;
        check("rst_new_head_rdy", {60'h0, in_ready}, 64'h4);
        @(negedge clk);
        drive(4'b0, 64'h0, 12'h0, 4'b0);
        #1;
        check("rst_new_head_out", {out_valid, out_data[31:16], out_src[3:2], out_last},
              {2'b10, 16'h0B01, 2'd2, 2'b10});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
